// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: FU requests in, granted writeback ports and per-FU stalls out.
// master drives requests (FU side); slave is the arbiter.
interface wb_port_arbiter_if #(
   parameter int NUM_FU  = 4,
   parameter int NUM_WBP = 2,
   parameter int INFO_W  = 128,
   parameter int CNT_W   = 32
);
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic                              i_flush;
   logic                              i_wb_stall;
   logic [NUM_FU-1:0]                 i_req_vld;
   logic [NUM_FU-1:0][INFO_W-1:0]     i_req_info;
   logic [NUM_FU-1:0]                 i_req_branch;
   logic [NUM_FU-1:0]                 o_req_stall;
   logic [NUM_WBP-1:0]                o_wb_vld;
   logic [NUM_WBP-1:0][INFO_W-1:0]    o_wb_info;
   logic [NUM_WBP-1:0][IDX_W-1:0]     o_wb_src;
   logic [CNT_W-1:0]                  o_conflict_cnt;

   modport master (
      output i_flush, i_wb_stall, i_req_vld, i_req_info, i_req_branch,
      input  o_req_stall, o_wb_vld, o_wb_info, o_wb_src, o_conflict_cnt
   );

   modport slave (
      input  i_flush, i_wb_stall, i_req_vld, i_req_info, i_req_branch,
      output o_req_stall, o_wb_vld, o_wb_info, o_wb_src, o_conflict_cnt
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of NUM_WBP writeback ports among NUM_FU fixed-latency FUs.
// Optional macro WBARB_BRANCH_PRIO_EN: branch results are granted ahead of other results.

// One writeback port output register; flush clears valid, stall freezes everything.
module wb_arb_port_reg #(
   parameter int INFO_W = 128,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              gnt_vld,
   input  logic [INFO_W-1:0] gnt_info,
   input  logic [IDX_W-1:0]  gnt_src,
   output logic              wb_vld,
   output logic [INFO_W-1:0] wb_info,
   output logic [IDX_W-1:0]  wb_src
);
   always_ff @(posedge clk) begin
      if (!rst)       wb_vld <= 1'b0;
      else if (flush) wb_vld <= 1'b0;
      else if (!stall) wb_vld <= gnt_vld;
   end

   always_ff @(posedge clk) begin
      if (!flush && !stall) begin
         wb_info <= gnt_info;
         wb_src  <= gnt_src;
      end
   end
endmodule

module wb_port_arbiter #(
   parameter int NUM_FU  = 4,
   parameter int NUM_WBP = 2,
   parameter int INFO_W  = 128,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   wb_port_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [IDX_W-1:0]               rr_ptr;
   logic [IDX_W-1:0]               last_idx;
   logic [NUM_FU-1:0]              grant;
   logic [NUM_FU-1:0]              grp [2];
   logic [NUM_WBP-1:0]             port_vld;
   logic [NUM_WBP-1:0][IDX_W-1:0]  port_src;
   logic [NUM_WBP-1:0]             wb_vld;
   logic [NUM_WBP-1:0][INFO_W-1:0] wb_info;
   logic [NUM_WBP-1:0][IDX_W-1:0]  wb_src;
   logic [CNT_W-1:0]               conflict_cnt;
   logic                           any_grant;
   logic                           conflict;
   logic                           advance;

   // Group 0 is scanned before group 1; without branch priority everyone is in group 0.
   always_comb begin
`ifdef WBARB_BRANCH_PRIO_EN
      grp[0] = bus.i_req_vld & bus.i_req_branch;
      grp[1] = bus.i_req_vld & ~bus.i_req_branch;
`else
      grp[0] = bus.i_req_vld;
      grp[1] = '0;
`endif
   end

   always_comb begin : grant_scan
      int n;
      int idx;
      n        = 0;
      idx      = 0;
      grant    = '0;
      port_vld = '0;
      port_src = '0;
      last_idx = rr_ptr;
      for (int g = 0; g < 2; g++) begin
         for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (grp[g][idx] && n < NUM_WBP) begin
               grant[idx]  = 1'b1;
               port_vld[n] = 1'b1;
               port_src[n] = IDX_W'(idx);
               last_idx    = IDX_W'(idx);
               n           = n + 1;
            end
         end
      end
   end

   assign any_grant = |grant;
   assign conflict  = $countones(bus.i_req_vld) > NUM_WBP;
   assign advance   = !bus.i_flush && !bus.i_wb_stall;

   // Losers hold their result; on flush nobody is held so FUs drop their results.
   assign bus.o_req_stall = {NUM_FU{bus.i_wb_stall}}
                          | (bus.i_req_vld & ~grant & {NUM_FU{~bus.i_flush}});

   generate
      for (genvar p = 0; p < NUM_WBP; p++) begin : g_port
         wb_arb_port_reg #(.INFO_W(INFO_W), .IDX_W(IDX_W)) u_reg (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.i_flush),
            .stall    (bus.i_wb_stall),
            .gnt_vld  (port_vld[p]),
            .gnt_info (bus.i_req_info[port_src[p]]),
            .gnt_src  (port_src[p]),
            .wb_vld   (wb_vld[p]),
            .wb_info  (wb_info[p]),
            .wb_src   (wb_src[p])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr       <= '0;
         conflict_cnt <= '0;
      end else if (advance) begin
         if (any_grant)
            rr_ptr <= (last_idx == IDX_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
         if (conflict && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   assign bus.o_wb_vld       = wb_vld;
   assign bus.o_wb_info      = wb_info;
   assign bus.o_wb_src       = wb_src;
   assign bus.o_conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based model of the grant rules.
// Small counter width so saturation is reached within the run.
module tb_wb_port_arbiter;
   localparam int NF = 4;
   localparam int NW = 2;
   localparam int IW = 128;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.NUM_FU(NF), .NUM_WBP(NW), .INFO_W(IW), .CNT_W(CW)) bus ();

   wb_port_arbiter #(.NUM_FU(NF), .NUM_WBP(NW), .INFO_W(IW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   int          m_rr = 0;
   int          m_cnt = 0;
   logic [NW-1:0] m_vld = '0;
   int          m_src [NW];
   logic [IW-1:0] m_info [NW];
   int          gq [$];

   task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Ordered candidate list: branch group first (when enabled), each scanned circularly from m_rr.
   function automatic void model_grant(input logic [NF-1:0] v, input logic [NF-1:0] br);
      int order [$];
      gq = {};
      for (int j = 0; j < NF; j++) order.push_back((m_rr + j) % NF);
`ifdef WBARB_BRANCH_PRIO_EN
      foreach (order[k]) if (v[order[k]] && br[order[k]]) gq.push_back(order[k]);
      foreach (order[k]) if (v[order[k]] && !br[order[k]]) gq.push_back(order[k]);
`else
      foreach (order[k]) if (v[order[k]]) gq.push_back(order[k]);
`endif
      while (gq.size() > NW) void'(gq.pop_back());
   endfunction

   task automatic check_outputs();
      for (int p = 0; p < NW; p++) begin
         chk($sformatf("wb_vld[%0d]", p), IW'(bus.o_wb_vld[p]), IW'(m_vld[p]));
         if (m_vld[p]) begin
            chk($sformatf("wb_src[%0d]", p), IW'(bus.o_wb_src[p]), IW'(m_src[p]));
            chk($sformatf("wb_info[%0d]", p), bus.o_wb_info[p], m_info[p]);
         end
      end
      chk("conflict_cnt", IW'(bus.o_conflict_cnt), IW'(m_cnt));
   endtask

   task automatic apply(input logic [NF-1:0] v, input logic [NF-1:0] br, input logic fl, input logic st);
      logic [NF-1:0] exp_stall;
      logic [NF-1:0] gmask;
      @(negedge clk);
      check_outputs();
      bus.i_req_vld    = v;
      bus.i_req_branch = br;
      bus.i_flush      = fl;
      bus.i_wb_stall   = st;
      for (int i = 0; i < NF; i++) bus.i_req_info[i] = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_grant(v, br);
      gmask = '0;
      foreach (gq[k]) gmask[gq[k]] = 1'b1;
      for (int i = 0; i < NF; i++) exp_stall[i] = st || (v[i] && !gmask[i] && !fl);
      chk("req_stall", IW'(bus.o_req_stall), IW'(exp_stall));
      if (fl) m_vld = '0;
      else if (!st) begin
         m_vld = '0;
         foreach (gq[k]) begin
            m_vld[k]  = 1'b1;
            m_src[k]  = gq[k];
            m_info[k] = bus.i_req_info[gq[k]];
         end
         if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % NF;
         if ($countones(v) > NW && m_cnt < (1 << CW) - 1) m_cnt++;
      end
   endtask

   initial begin
      bus.i_req_vld    = '0;
      bus.i_req_branch = '0;
      bus.i_flush      = 1'b0;
      bus.i_wb_stall   = 1'b0;
      bus.i_req_info   = '0;
      repeat (3) @(negedge clk);
      chk("rst wb_vld", IW'(bus.o_wb_vld), '0);
      chk("rst conflict_cnt", IW'(bus.o_conflict_cnt), '0);
      rst = 1'b1;

      // directed: two requests, all four, stall hold, flush, wrap, branch mix
      apply(4'b0101, 4'b0000, 1'b0, 1'b0);
      apply(4'b1111, 4'b0000, 1'b0, 1'b0);
      apply(4'b1111, 4'b0000, 1'b0, 1'b0);
      repeat (3) apply(4'b1111, 4'b0000, 1'b0, 1'b1);
      apply(4'b1110, 4'b0000, 1'b1, 1'b0);
      apply(4'b1110, 4'b0000, 1'b1, 1'b1);
      apply(4'b0100, 4'b0000, 1'b0, 1'b0);
      apply(4'b1001, 4'b0000, 1'b0, 1'b0);
      apply(4'b1111, 4'b1000, 1'b0, 1'b0);
      apply(4'b0000, 4'b0000, 1'b0, 1'b0);

      for (int c = 0; c < 400; c++)
         apply(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));

      apply(4'b0000, 4'b0000, 1'b0, 1'b0);
      apply(4'b0000, 4'b0000, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares NUM_WBP integer writeback ports among NUM_FU fixed-latency FUs (alu_bru-class) that present one registered finished/comwb result per cycle.
- Grants up to NUM_WBP requesters per cycle in round-robin order and stalls the losers; a stalled FU holds its result.
- Sits between the FU output stage and the register-file write / ROB-complete logic.

Parameters:
- NUM_FU, 4, number of requesting FUs (2..8)
- NUM_WBP, 2, number of writeback ports (1..NUM_FU)
- INFO_W, 128, flattened comwbInfo_t payload width
- CNT_W, 32, width of the conflict performance counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- i_flush  in  1  pipeline flush; drop this cycle's requests and outputs
- i_wb_stall  in  1  downstream cannot accept writeback this cycle
- i_req_vld  in  NUM_FU  FU i has a finished result (o_fu_finished)
- i_req_info  in  NUM_FU*INFO_W  FU i payload, slice i
- i_req_branch  in  NUM_FU  FU i result is a branch (used only with the optional feature)
- o_req_stall  out  NUM_FU  per-FU stall, fed back to that FU's i_wb_stall
- o_wb_vld  out  NUM_WBP  port p valid
- o_wb_info  out  NUM_WBP*INFO_W  port p payload
- o_wb_src  out  NUM_WBP*$clog2(NUM_FU)  index of the FU granted on port p
- o_conflict_cnt  out  CNT_W  count of cycles in which valid requests exceeded NUM_WBP

Behaviour:
- Reset (rst==0): o_wb_vld=0, rr_ptr=0, o_conflict_cnt=0. o_wb_info and o_wb_src are don't-care.
- Grant is combinational:
  - Scan FUs circularly from rr_ptr.
  - The first NUM_WBP with i_req_vld=1 are granted.
  - The k-th granted FU goes to port k; ports with no grant carry valid=0.
- o_req_stall[i] = i_wb_stall | (i_req_vld[i] & ~grant[i] & ~i_flush).
  - This is combinational from registered FU outputs only; there is no loop.
  - A non-requesting FU is stalled only by i_wb_stall.
- Output registers, latency 1 cycle from grant:
  - If i_flush: o_wb_vld <= 0, whatever the state of i_wb_stall.
  - Else if i_wb_stall: all outputs hold and rr_ptr holds.
  - Else: o_wb_vld[p] <= port p granted; o_wb_info and o_wb_src load from the granted FU.
- rr_ptr update:
  - Only when !i_wb_stall, !i_flush and at least one grant: rr_ptr <= (last granted index + 1) mod NUM_FU.
  - Wrap from NUM_FU-1 to 0.
- Fairness: a requester that stays continuously valid is granted within ceil(NUM_FU/NUM_WBP) non-stalled cycles.
- Flush:
  - All grants are discarded and no o_req_stall is raised for losers, so FUs drop their results.
  - rr_ptr is unchanged.
- Simultaneous i_flush and i_wb_stall: flush wins for o_wb_vld (cleared); o_req_stall follows i_wb_stall.
- Counter:
  - Increments when popcount(i_req_vld) > NUM_WBP, !i_flush and !i_wb_stall.
  - Saturates at all-ones; no wrap.
- When requests ≤ NUM_WBP, every request is granted and no FU stalls.

Optional Feature:
- Macro WBARB_BRANCH_PRIO_EN.
- Defined:
  - Requesters with i_req_branch=1 form a higher-priority group and are granted first, round-robin from rr_ptr within the group.
  - Remaining ports go to non-branch requesters, round-robin from rr_ptr.
  - rr_ptr advances past the last granted index overall.
  - Purpose: mispredict redirects reach the frontend early.
- Not defined: i_req_branch is ignored; plain round-robin applies.

Test Plan:
- Reset, then NUM_FU=4/NUM_WBP=2 with i_req_vld=4'b0101 -> next cycle o_wb_vld=2'b11, o_wb_src={2,0}, o_req_stall=0, counter stays 0.
- i_req_vld=4'b1111 held for 2 non-stalled cycles, rr_ptr=0 -> cycle 1 grants FU0,1 and stalls FU2,3; cycle 2 grants FU2,3; o_conflict_cnt=2.
- i_req_vld=4'b1111 with i_wb_stall=1 for 3 cycles -> all o_req_stall=1; outputs and rr_ptr frozen; counter unchanged.
- i_req_vld=4'b1110 and i_flush=1 -> next cycle o_wb_vld=0, o_req_stall=0, rr_ptr unchanged.
- rr_ptr=3, i_req_vld=4'b1001 -> port0=FU3, port1=FU0 (wrap); rr_ptr becomes 1.
- WBARB_BRANCH_PRIO_EN, rr_ptr=0, i_req_vld=4'b1111, i_req_branch=4'b1000 -> port0=FU3, port1=FU0; FU1 and FU2 stalled.
